// File: rtl/buffer_arbiter_if.sv
// Buffer-access handshake bundle between the image writer/reader FSMs
// (master) and the frame-buffer arbiter (slave).
interface buffer_arbiter_if #(
  parameter int BANK_W = 1
);
  logic              rq_write;
  logic              writing;
  logic              ack_write;
  logic              rq_read;
  logic              reading;
  logic              ack_read;
  logic [BANK_W-1:0] wr_bank;
  logic [BANK_W-1:0] rd_bank;
  logic [BANK_W:0]   full_count;
  logic              grant_abort;

  modport master (
    output rq_write, writing, rq_read, reading,
    input  ack_write, ack_read, wr_bank, rd_bank, full_count, grant_abort
  );

  modport slave (
    input  rq_write, writing, rq_read, reading,
    output ack_write, ack_read, wr_bank, rd_bank, full_count, grant_abort
  );
endinterface

// File: rtl/buffer_arbiter.sv
// Frame-buffer arbiter: grants one writer and one reader access to a
// NUM_BANKS-deep ping-pong buffer and steers bank pointers so the two
// never share a bank. Optional grant timeout under macro ARB_TIMEOUT_EN.
//
// Per-side FSM states:
//   state     | meaning
//   ST_IDLE   | no grant; waiting for a request that can be served
//   ST_GRANT  | ack high, waiting for the session input to rise
//   ST_ACTIVE | session open; its falling edge commits the bank
module buffer_arbiter #(
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = 1
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  buffer_arbiter_if.slave    bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [BANK_W:0]   NB_FULL   = (BANK_W+1)'(NUM_BANKS);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  logic [1:0]        w_state, r_state;
  logic              ack_write_q, ack_read_q;
  logic [BANK_W-1:0] wr_bank_q, rd_bank_q;
  logic [BANK_W:0]   full_q;
  logic              w_commit, r_commit;
  logic              w_abort, r_abort;

  assign w_commit = (w_state == ST_ACTIVE) && !bus.writing;
  assign r_commit = (r_state == ST_ACTIVE) && !bus.reading;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] w_cnt, r_cnt;
  logic             abort_q;

  // Down-counters reload while idle so each grant starts a fresh window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_cnt <= CNT_LOAD;
      r_cnt <= CNT_LOAD;
    end else begin
      if (w_state == ST_IDLE)
        w_cnt <= CNT_LOAD;
      else if ((w_state == ST_GRANT) && (w_cnt != '0))
        w_cnt <= w_cnt - 1'b1;
      if (r_state == ST_IDLE)
        r_cnt <= CNT_LOAD;
      else if ((r_state == ST_GRANT) && (r_cnt != '0))
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_abort = (w_state == ST_GRANT) && !bus.writing && (w_cnt == '0);
  assign r_abort = (r_state == ST_GRANT) && !bus.reading && (r_cnt == '0);

  // One pulse even when both sides time out together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) abort_q <= 1'b0;
    else       abort_q <= w_abort | r_abort;
  end

  assign bus.grant_abort = abort_q;
`else
  assign w_abort         = 1'b0;
  assign r_abort         = 1'b0;
  assign bus.grant_abort = 1'b0;
`endif

  // Writer side: grant only when a free bank exists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state     <= ST_IDLE;
      ack_write_q <= 1'b0;
    end else begin
      case (w_state)
        ST_IDLE: if (bus.rq_write && (full_q < NB_FULL)) begin
          ack_write_q <= 1'b1;
          w_state     <= ST_GRANT;
        end
        ST_GRANT: if (bus.writing) begin
          w_state <= ST_ACTIVE;
        end else if (w_abort) begin
          ack_write_q <= 1'b0;
          w_state     <= ST_IDLE;
        end
        ST_ACTIVE: if (!bus.writing) begin
          ack_write_q <= 1'b0;
          w_state     <= ST_IDLE;
        end
        default: begin
          ack_write_q <= 1'b0;
          w_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Reader side: grant only when a committed bank exists.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      ack_read_q <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.rq_read && (full_q != '0)) begin
          ack_read_q <= 1'b1;
          r_state    <= ST_GRANT;
        end
        ST_GRANT: if (bus.reading) begin
          r_state <= ST_ACTIVE;
        end else if (r_abort) begin
          ack_read_q <= 1'b0;
          r_state    <= ST_IDLE;
        end
        ST_ACTIVE: if (!bus.reading) begin
          ack_read_q <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          ack_read_q <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Commits advance the owning pointer and adjust the committed-bank count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      full_q    <= '0;
    end else begin
      if (w_commit)
        wr_bank_q <= (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + 1'b1;
      if (r_commit)
        rd_bank_q <= (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + 1'b1;
      case ({w_commit, r_commit})
        2'b10:   full_q <= full_q + 1'b1;
        2'b01:   full_q <= full_q - 1'b1;
        default: full_q <= full_q;
      endcase
    end
  end

  assign bus.ack_write  = ack_write_q;
  assign bus.ack_read   = ack_read_q;
  assign bus.wr_bank    = wr_bank_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.full_count = full_q;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter (NUM_BANKS=2). Define ARB_TIMEOUT_EN
// for both RTL and bench to exercise the grant timeout.
module tb_buffer_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  buffer_arbiter_if #(.BANK_W(1)) bus ();

  buffer_arbiter #(.NUM_BANKS(2), .BANK_W(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.rq_write = 1'b0;
    bus.writing  = 1'b0;
    bus.rq_read  = 1'b0;
    bus.reading  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Full write transaction assuming an immediate grant.
  task automatic do_write();
    bus.rq_write = 1'b1;
    tick();
    bus.rq_write = 1'b0;
    bus.writing  = 1'b1;
    tick();
    bus.writing  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    total++;
    if ({bus.ack_write, bus.ack_read, bus.wr_bank, bus.rd_bank, bus.full_count, bus.grant_abort} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 0000000",
               {bus.ack_write, bus.ack_read, bus.wr_bank, bus.rd_bank, bus.full_count, bus.grant_abort});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    do_reset();
    bus.rq_write = 1'b1;
    tick();
    total++;
    if (bus.ack_write !== 1'b1) begin
      bad++; $display("FAIL sw_grant: ack_write got %b want 1", bus.ack_write);
    end
    bus.rq_write = 1'b0;
    bus.writing  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (bus.ack_write !== 1'b1 || bus.full_count !== 2'd0) begin
      bad++; $display("FAIL sw_active: ack_write=%b full=%0d want 1/0", bus.ack_write, bus.full_count);
    end
    bus.writing = 1'b0;
    tick();
    total++;
    if (bus.ack_write !== 1'b0 || bus.full_count !== 2'd1 || bus.wr_bank !== 1'b1 || bus.rd_bank !== 1'b0) begin
      bad++;
      $display("FAIL sw_commit: ack=%b full=%0d wr=%0d rd=%0d want 0/1/1/0",
               bus.ack_write, bus.full_count, bus.wr_bank, bus.rd_bank);
    end
  endtask

  task automatic test_read_empty();
    int grants;
    do_reset();
    bus.rq_read = 1'b1;
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack_read !== 1'b0) grants++;
    end
    total++;
    if (grants != 0) begin
      bad++; $display("FAIL re_hold: ack_read high on %0d cycles want 0", grants);
    end
    do_write();
    total++;
    if (bus.full_count !== 2'd1 || bus.ack_read !== 1'b0) begin
      bad++; $display("FAIL re_commit: full=%0d ack_read=%b want 1/0", bus.full_count, bus.ack_read);
    end
    tick();
    total++;
    if (bus.ack_read !== 1'b1 || bus.rd_bank !== 1'b0) begin
      bad++; $display("FAIL re_grant: ack_read=%b rd=%0d want 1/0", bus.ack_read, bus.rd_bank);
    end
    bus.rq_read = 1'b0;
    bus.reading = 1'b1;
    tick();
    bus.reading = 1'b0;
    tick();
    total++;
    if (bus.ack_read !== 1'b0 || bus.full_count !== 2'd0 || bus.rd_bank !== 1'b1) begin
      bad++;
      $display("FAIL re_done: ack_read=%b full=%0d rd=%0d want 0/0/1", bus.ack_read, bus.full_count, bus.rd_bank);
    end
  endtask

  task automatic test_full();
    int grants;
    do_reset();
    do_write();
    do_write();
    total++;
    if (bus.full_count !== 2'd2 || bus.wr_bank !== 1'b0) begin
      bad++; $display("FAIL full_two: full=%0d wr=%0d want 2/0", bus.full_count, bus.wr_bank);
    end
    bus.rq_write = 1'b1;
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.ack_write !== 1'b0) grants++;
    end
    total++;
    if (grants != 0) begin
      bad++; $display("FAIL full_block: ack_write high on %0d cycles want 0", grants);
    end
    bus.rq_read = 1'b1;
    tick();
    bus.rq_read = 1'b0;
    bus.reading = 1'b1;
    tick();
    bus.reading = 1'b0;
    tick();
    total++;
    if (bus.full_count !== 2'd1 || bus.rd_bank !== 1'b1 || bus.ack_write !== 1'b0) begin
      bad++;
      $display("FAIL full_read: full=%0d rd=%0d ack_write=%b want 1/1/0", bus.full_count, bus.rd_bank, bus.ack_write);
    end
    tick();
    total++;
    if (bus.ack_write !== 1'b1 || bus.wr_bank !== 1'b0) begin
      bad++; $display("FAIL full_regrant: ack_write=%b wr=%0d want 1/0", bus.ack_write, bus.wr_bank);
    end
    bus.rq_write = 1'b0;
    bus.writing  = 1'b1;
    tick();
    bus.writing  = 1'b0;
    tick();
    total++;
    if (bus.full_count !== 2'd2 || bus.wr_bank !== 1'b1) begin
      bad++; $display("FAIL full_wrap: full=%0d wr=%0d want 2/1", bus.full_count, bus.wr_bank);
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    do_write();
    bus.rq_write = 1'b1;
    bus.rq_read  = 1'b1;
    tick();
    total++;
    if (bus.ack_write !== 1'b1 || bus.ack_read !== 1'b1 || bus.wr_bank !== 1'b1 || bus.rd_bank !== 1'b0) begin
      bad++;
      $display("FAIL cc_grant: ackw=%b ackr=%b wr=%0d rd=%0d want 1/1/1/0",
               bus.ack_write, bus.ack_read, bus.wr_bank, bus.rd_bank);
    end
    bus.rq_write = 1'b0;
    bus.rq_read  = 1'b0;
    bus.writing  = 1'b1;
    bus.reading  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.writing = 1'b0;
    bus.reading = 1'b0;
    tick();
    total++;
    if (bus.ack_write !== 1'b0 || bus.ack_read !== 1'b0 || bus.full_count !== 2'd1 ||
        bus.wr_bank !== 1'b0 || bus.rd_bank !== 1'b1) begin
      bad++;
      $display("FAIL cc_commit: ackw=%b ackr=%b full=%0d wr=%0d rd=%0d want 0/0/1/0/1",
               bus.ack_write, bus.ack_read, bus.full_count, bus.wr_bank, bus.rd_bank);
    end
  endtask

  task automatic test_rq_with_session();
    do_reset();
    bus.rq_write = 1'b1;
    bus.writing  = 1'b1;
    tick();
    tick();
    total++;
    if (bus.ack_write !== 1'b1 || bus.full_count !== 2'd0) begin
      bad++; $display("FAIL rs_active: ack=%b full=%0d want 1/0", bus.ack_write, bus.full_count);
    end
    bus.rq_write = 1'b0;
    bus.writing  = 1'b0;
    tick();
    total++;
    if (bus.ack_write !== 1'b0 || bus.full_count !== 2'd1 || bus.wr_bank !== 1'b1) begin
      bad++;
      $display("FAIL rs_commit: ack=%b full=%0d wr=%0d want 0/1/1", bus.ack_write, bus.full_count, bus.wr_bank);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    do_write();
    bus.rq_write = 1'b1;
    bus.rq_read  = 1'b1;
    tick();
    bus.rq_write = 1'b0;
    bus.rq_read  = 1'b0;
    bus.writing  = 1'b1;
    bus.reading  = 1'b1;
    tick();
    tick();
    total++;
    if (bus.ack_write !== 1'b1 || bus.ack_read !== 1'b1) begin
      bad++; $display("FAIL mr_active: ackw=%b ackr=%b want 1/1", bus.ack_write, bus.ack_read);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.ack_write !== 1'b0 || bus.ack_read !== 1'b0 || bus.full_count !== 2'd0 ||
        bus.wr_bank !== 1'b0 || bus.rd_bank !== 1'b0) begin
      bad++;
      $display("FAIL mr_reset: ackw=%b ackr=%b full=%0d wr=%0d rd=%0d want all 0",
               bus.ack_write, bus.ack_read, bus.full_count, bus.wr_bank, bus.rd_bank);
    end
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    do_reset();
    bus.rq_write = 1'b1;
    tick();
    bus.rq_write = 1'b0;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.ack_write !== 1'b1 || bus.grant_abort !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin
      bad++; $display("FAIL to_window: early drop/abort on %0d cycles want 0", early);
    end
    tick();
    total++;
    if (bus.ack_write !== 1'b0 || bus.grant_abort !== 1'b1 || bus.full_count !== 2'd0 || bus.wr_bank !== 1'b0) begin
      bad++;
      $display("FAIL to_abort: ack=%b abort=%b full=%0d wr=%0d want 0/1/0/0",
               bus.ack_write, bus.grant_abort, bus.full_count, bus.wr_bank);
    end
    tick();
    total++;
    if (bus.grant_abort !== 1'b0) begin
      bad++; $display("FAIL to_pulse: abort=%b want 0", bus.grant_abort);
    end
  endtask
`else
  task automatic test_no_timeout();
    int drops;
    do_reset();
    bus.rq_write = 1'b1;
    tick();
    bus.rq_write = 1'b0;
    drops = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ack_write !== 1'b1 || bus.grant_abort !== 1'b0) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++; $display("FAIL nt_hold: grant lost/abort on %0d cycles want 0", drops);
    end
    bus.writing = 1'b1;
    tick();
    bus.writing = 1'b0;
    tick();
    total++;
    if (bus.ack_write !== 1'b0 || bus.full_count !== 2'd1) begin
      bad++; $display("FAIL nt_commit: ack=%b full=%0d want 0/1", bus.ack_write, bus.full_count);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_read_empty();
    test_full();
    test_concurrent();
    test_rq_with_session();
    test_mid_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
